// File: rtl/regfile_write_buffer.sv
// rtl/regfile_write_buffer.sv - FIFO write buffer in front of the register file write port
//
// Queues writeback requests (in_rd/in_data) and retires one per cycle onto the
// register file write port (rd/writedata/regwrite). Reports pending writes to
// the read-side query addresses rs/rt.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   writeback request handshake; in_rd, in_data request payload
//   wb_hold             suppresses draining this cycle
//   rd, writedata       registered register-file write address/data
//   regwrite            register-file write enable, one cycle per drained entry
//   rs, rt              read-side query addresses
//   pend_rs, pend_rt    a write to rs/rt is queued or on the write port
//   count               queued entries, excluding the output stage
//   fwd_rs_data,
//   fwd_rt_data         data of the youngest pending write to rs/rt
//                       (present only when WB_BYPASS_EN is defined)
//
// Optional feature macro: WB_BYPASS_EN

module regfile_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ADDR_W-1:0]       in_rd,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    wb_hold,
    output logic [ADDR_W-1:0]       rd,
    output logic [DATA_W-1:0]       writedata,
    output logic                    regwrite,
    input  logic [ADDR_W-1:0]       rs,
    input  logic [ADDR_W-1:0]       rt,
    output logic                    pend_rs,
    output logic                    pend_rt,
    output logic [$clog2(DEPTH):0]  count
`ifdef WB_BYPASS_EN
    ,
    output logic [DATA_W-1:0]       fwd_rs_data,
    output logic [DATA_W-1:0]       fwd_rt_data
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] mem_rd   [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic              push;
    logic              pop;

    // in_ready looks only at count, so a full buffer refuses a request even
    // when an entry leaves in the same cycle.
    assign in_ready = (count < FULL_CNT);

    // Writes to register 0 complete the handshake but are discarded.
    assign push = in_valid && in_ready && (in_rd != '0);

    // Pop decision uses the pre-edge count: an entry pushed into an empty
    // buffer is never popped in that same edge.
    assign pop = !wb_hold && (count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            rd        <= '0;
            writedata <= '0;
            regwrite  <= 1'b0;
        end else begin
            if (push) begin
                mem_rd[wptr]   <= in_rd;
                mem_data[wptr] <= in_data;
                wptr           <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rd        <= mem_rd[rptr];
                writedata <= mem_data[rptr];
                rptr      <= rptr + PTR_W'(1);
            end
            regwrite <= pop;
            count    <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Scan occupied slots oldest to youngest so that, for forwarding, a later
    // match overrides an earlier one and the youngest write wins.
    logic             hit_rs;
    logic             hit_rt;
    logic [PTR_W-1:0] idx;

    always_comb begin
        hit_rs = regwrite && (rd == rs);
        hit_rt = regwrite && (rd == rt);
        idx    = rptr;
`ifdef WB_BYPASS_EN
        fwd_rs_data = (regwrite && (rd == rs)) ? writedata : '0;
        fwd_rt_data = (regwrite && (rd == rt)) ? writedata : '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            idx = rptr + PTR_W'(k);
            if (CNT_W'(k) < count) begin
                if (mem_rd[idx] == rs) begin
                    hit_rs = 1'b1;
`ifdef WB_BYPASS_EN
                    fwd_rs_data = mem_data[idx];
`endif
                end
                if (mem_rd[idx] == rt) begin
                    hit_rt = 1'b1;
`ifdef WB_BYPASS_EN
                    fwd_rt_data = mem_data[idx];
`endif
                end
            end
        end
    end

    // Register 0 is never written, so it is never reported as pending.
    assign pend_rs = (rs != '0) && hit_rs;
    assign pend_rt = (rt != '0) && hit_rt;

endmodule

// File: tb/tb_regfile_write_buffer.sv
// tb/tb_regfile_write_buffer.sv - self-checking bench for regfile_write_buffer
module tb_regfile_write_buffer;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [ADDR_W-1:0] in_rd = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic              wb_hold = 1'b0;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] writedata;
    logic              regwrite;
    logic [ADDR_W-1:0] rs = '0;
    logic [ADDR_W-1:0] rt = '0;
    logic              pend_rs;
    logic              pend_rt;
    logic [2:0]        count;
`ifdef WB_BYPASS_EN
    logic [DATA_W-1:0] fwd_rs_data;
    logic [DATA_W-1:0] fwd_rt_data;
`endif

    always #5 clk = ~clk;

    regfile_write_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_data(in_data), .wb_hold(wb_hold),
        .rd(rd), .writedata(writedata), .regwrite(regwrite),
        .rs(rs), .rt(rt), .pend_rs(pend_rs), .pend_rt(pend_rt), .count(count)
`ifdef WB_BYPASS_EN
        , .fwd_rs_data(fwd_rs_data), .fwd_rt_data(fwd_rt_data)
`endif
    );

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    // Reference model: a queue of pending writes plus the write-port stage.
    ent_t              mq[$];
    logic              m_rw = 1'b0;
    logic [ADDR_W-1:0] m_rd = '0;
    logic [DATA_W-1:0] m_wd = '0;
    bit                acc;
    int                errors = 0;
    int                checks = 0;

    function automatic logic exp_pend(input logic [ADDR_W-1:0] a);
        logic h;
        h = m_rw && (m_rd == a);
        foreach (mq[i]) if (mq[i].a == a) h = 1'b1;
        return (a != '0) && h;
    endfunction

    function automatic logic [DATA_W-1:0] exp_fwd(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = (m_rw && (m_rd == a)) ? m_wd : '0;
        foreach (mq[i]) if (mq[i].a == a) v = mq[i].d;
        return v;
    endfunction

    // One clock: advance the model with the inputs present before the edge,
    // return at the following falling edge.
    task automatic step();
        bit   push;
        bit   pop;
        ent_t e;
        acc  = in_valid && (mq.size() < DEPTH);
        push = acc && (in_rd != '0);
        pop  = !wb_hold && (mq.size() > 0);
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_rw = 1'b0;
            m_rd = '0;
            m_wd = '0;
        end else begin
            if (pop) begin
                e    = mq.pop_front();
                m_rd = e.a;
                m_wd = e.d;
            end
            m_rw = pop;
            if (push) mq.push_back({in_rd, in_data});
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        wb_hold  = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_rd = 5'd7; in_data = 32'd9;
        step(); step();
        rst = 1'b0; in_valid = 1'b0; rs = 5'd7; rt = 5'd7;
        #1;
        checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite: got %0d expected 0", regwrite); end
        checks++; if (rd !== '0) begin errors++; $display("FAIL reset_rd: got %0d expected 0", rd); end
        checks++; if (writedata !== '0) begin errors++; $display("FAIL reset_writedata: got %0d expected 0", writedata); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0d expected 1", in_ready); end
        checks++; if (pend_rs !== 1'b0) begin errors++; $display("FAIL reset_pend_rs: got %0d expected 0", pend_rs); end
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_rd = 5'd3; in_data = 32'd100; rs = 5'd3; wb_hold = 1'b0;
        step();                                       // E0
        in_valid = 1'b0;
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count_e0: got %0d expected 1", count); end
        checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL single_rw_e0: got %0d expected 0", regwrite); end
        checks++; if (pend_rs !== 1'b1) begin errors++; $display("FAIL single_pend_e0: got %0d expected 1", pend_rs); end
        step();                                       // E1
        checks++; if (regwrite !== 1'b1) begin errors++; $display("FAIL single_rw_e1: got %0d expected 1", regwrite); end
        checks++; if (rd !== 5'd3) begin errors++; $display("FAIL single_rd_e1: got %0d expected 3", rd); end
        checks++; if (writedata !== 32'd100) begin errors++; $display("FAIL single_wd_e1: got %0d expected 100", writedata); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_count_e1: got %0d expected 0", count); end
        checks++; if (pend_rs !== 1'b1) begin errors++; $display("FAIL single_pend_e1: got %0d expected 1", pend_rs); end
        step();                                       // E2
        checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL single_rw_e2: got %0d expected 0", regwrite); end
        checks++; if (pend_rs !== 1'b0) begin errors++; $display("FAIL single_pend_e2: got %0d expected 0", pend_rs); end
    endtask

    task automatic test_full_hold();
        bit seen5;
        int acc_cycle;
        wb_hold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_rd = ADDR_W'(i); in_data = DATA_W'(i * 10);
            step();
        end
        in_rd = 5'd5; in_data = 32'd50;
        #1;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %0d expected 0", in_ready); end
        step();
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_reject: got %0d expected 4", count); end
        wb_hold = 1'b0;
        seen5 = 1'b0; acc_cycle = -1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (acc && in_valid) begin acc_cycle = i; in_valid = 1'b0; end
            checks++; if (regwrite !== 1'b1 || rd !== ADDR_W'(i + 1) || writedata !== DATA_W'((i + 1) * 10))
                begin errors++; $display("FAIL full_drain[%0d]: got rw=%0d rd=%0d wd=%0d expected rw=1 rd=%0d wd=%0d", i, regwrite, rd, writedata, i + 1, (i + 1) * 10); end
        end
        checks++; if (acc_cycle != 1) begin errors++; $display("FAIL full_fifth_accept: got cycle %0d expected 1", acc_cycle); end
        idle(3);
    endtask

    task automatic test_zero_rd();
        in_valid = 1'b1; in_rd = 5'd0; in_data = 32'd55; rs = 5'd0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL zero_in_ready: got %0d expected 1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL zero_count: got %0d expected 0", count); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL zero_regwrite[%0d]: got %0d expected 0", i, regwrite); end
        end
        checks++; if (pend_rs !== 1'b0) begin errors++; $display("FAIL zero_pend_rs: got %0d expected 0", pend_rs); end
    endtask

    task automatic test_same_reg();
        wb_hold = 1'b1; rt = 5'd6;
        in_valid = 1'b1; in_rd = 5'd6; in_data = 32'd100; step();
        in_data = 32'd200; step();
        in_valid = 1'b0;
        #1;
        checks++; if (pend_rt !== 1'b1) begin errors++; $display("FAIL same_pend_rt: got %0d expected 1", pend_rt); end
`ifdef WB_BYPASS_EN
        checks++; if (fwd_rt_data !== 32'd200) begin errors++; $display("FAIL same_fwd_rt: got %0d expected 200", fwd_rt_data); end
`endif
        wb_hold = 1'b0;
        step();
        checks++; if (regwrite !== 1'b1 || rd !== 5'd6 || writedata !== 32'd100) begin errors++; $display("FAIL same_first: got rw=%0d rd=%0d wd=%0d expected rw=1 rd=6 wd=100", regwrite, rd, writedata); end
`ifdef WB_BYPASS_EN
        checks++; if (fwd_rt_data !== 32'd200) begin errors++; $display("FAIL same_fwd_mid: got %0d expected 200", fwd_rt_data); end
`endif
        step();
        checks++; if (regwrite !== 1'b1 || rd !== 5'd6 || writedata !== 32'd200) begin errors++; $display("FAIL same_second: got rw=%0d rd=%0d wd=%0d expected rw=1 rd=6 wd=200", regwrite, rd, writedata); end
        idle(2);
    endtask

    task automatic test_back_to_back();
        ent_t sb[$];
        ent_t e;
        wb_hold = 1'b1;
        in_valid = 1'b1; in_rd = ADDR_W'($urandom_range(1, 31)); in_data = $urandom;
        for (int i = 0; i < DEPTH; i++) begin
            step();
            if (acc) begin
                sb.push_back({in_rd, in_data});
                in_rd = ADDR_W'($urandom_range(1, 31)); in_data = $urandom;
            end
        end
        wb_hold = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (acc) begin
                sb.push_back({in_rd, in_data});
                in_rd = ADDR_W'($urandom_range(1, 31)); in_data = $urandom;
            end
            checks++; if (count !== 3'(DEPTH - 1) && count !== 3'(DEPTH)) begin errors++; $display("FAIL b2b_count[%0d]: got %0d expected 3 or 4", i, count); end
            checks++; if (regwrite !== 1'b1) begin errors++; $display("FAIL b2b_regwrite[%0d]: got %0d expected 1", i, regwrite); end
            else begin
                e = sb.pop_front();
                checks++; if (rd !== e.a || writedata !== e.d) begin errors++; $display("FAIL b2b_data[%0d]: got rd=%0d wd=%0h expected rd=%0d wd=%0h", i, rd, writedata, e.a, e.d); end
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            step();
            if (regwrite === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                checks++; if (rd !== e.a || writedata !== e.d) begin errors++; $display("FAIL b2b_tail[%0d]: got rd=%0d wd=%0h expected rd=%0d wd=%0h", i, rd, writedata, e.a, e.d); end
            end
        end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b_lost: got %0d undrained expected 0", sb.size()); end
    endtask

    task automatic test_random();
        in_valid = 1'b0; acc = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 9) < 6);
                in_rd    = ADDR_W'($urandom_range(0, 7));
                in_data  = $urandom;
            end
            wb_hold = ($urandom_range(0, 3) == 0);
            rs = ADDR_W'($urandom_range(0, 7));
            rt = ADDR_W'($urandom_range(0, 7));
            #1;
            checks++; if (in_ready !== (mq.size() < DEPTH)) begin errors++; $display("FAIL rnd_in_ready[%0d]: got %0d expected %0d", i, in_ready, mq.size() < DEPTH); end
            checks++; if (pend_rs !== exp_pend(rs) || pend_rt !== exp_pend(rt)) begin errors++; $display("FAIL rnd_pend[%0d]: got %0d%0d expected %0d%0d", i, pend_rs, pend_rt, exp_pend(rs), exp_pend(rt)); end
`ifdef WB_BYPASS_EN
            if (exp_pend(rs)) begin checks++; if (fwd_rs_data !== exp_fwd(rs)) begin errors++; $display("FAIL rnd_fwd_rs[%0d]: got %0h expected %0h", i, fwd_rs_data, exp_fwd(rs)); end end
            if (exp_pend(rt)) begin checks++; if (fwd_rt_data !== exp_fwd(rt)) begin errors++; $display("FAIL rnd_fwd_rt[%0d]: got %0h expected %0h", i, fwd_rt_data, exp_fwd(rt)); end end
`endif
            step();
            checks++; if (count !== 3'(mq.size())) begin errors++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", i, count, mq.size()); end
            checks++; if (regwrite !== m_rw || rd !== m_rd || writedata !== m_wd) begin errors++; $display("FAIL rnd_port[%0d]: got rw=%0d rd=%0d wd=%0h expected rw=%0d rd=%0d wd=%0h", i, regwrite, rd, writedata, m_rw, m_rd, m_wd); end
        end
        idle(DEPTH + 2);
    endtask

    task automatic test_reset_mid();
        wb_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_rd = ADDR_W'(9 + i); in_data = DATA_W'(900 + i);
            step();
        end
        in_valid = 1'b0; wb_hold = 1'b0; rs = 5'd10; rt = 5'd9;
        step();
        checks++; if (regwrite !== 1'b1 || count !== 3'd3) begin errors++; $display("FAIL mid_pre: got rw=%0d count=%0d expected rw=1 count=3", regwrite, count); end
        checks++; if (pend_rs !== 1'b1 || pend_rt !== 1'b1) begin errors++; $display("FAIL mid_pre_pend: got %0d%0d expected 11", pend_rs, pend_rt); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL mid_regwrite: got %0d expected 0", regwrite); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", count); end
        checks++; if (pend_rs !== 1'b0 || pend_rt !== 1'b0) begin errors++; $display("FAIL mid_pend: got %0d%0d expected 00", pend_rs, pend_rt); end
        checks++; if (rd !== '0 || writedata !== '0) begin errors++; $display("FAIL mid_port: got rd=%0d wd=%0d expected 0 0", rd, writedata); end
        step();
        checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL mid_after: got %0d expected 0", regwrite); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_hold();
        test_zero_rd();
        test_same_reg();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
